// File: rtl/max_pool_2x2_stream.sv
// Streaming 2x2 stride-2 signed max-pool over a raster-order feature map.
// Even-row pair maxima wait in a half-width line buffer for the odd row.
module max_pool_2x2_stream #(
    parameter int In_d_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [In_d_W-1:0] A,
    output logic signed [In_d_W-1:0] Y,
    output logic                     valid,
    output logic                     frame_done
);

    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);
    localparam int LBN = IMG_W / 2;
    localparam int LW  = (LBN > 1) ? $clog2(LBN) : 1;

    logic        [CW-1:0]     r_col;
    logic        [RW-1:0]     r_row;
    logic signed [In_d_W-1:0] r_hold;
    logic signed [In_d_W-1:0] r_lb [LBN];

    logic        [LW-1:0]     w_idx;
    logic                     w_col_last;
    logic                     w_row_last;
    logic signed [In_d_W-1:0] w_pm;
    logic signed [In_d_W-1:0] w_lb;
    logic signed [In_d_W-1:0] w_win;

    assign w_idx      = LW'(r_col >> 1);
    assign w_col_last = (r_col == CW'(IMG_W - 1));
    assign w_row_last = (r_row == RW'(IMG_H - 1));
    assign w_pm       = (r_hold > A) ? r_hold : A;
    assign w_lb       = r_lb[w_idx];
    assign w_win      = (w_lb > w_pm) ? w_lb : w_pm;

    always_ff @(posedge clk) begin
        if (rst) begin
            Y          <= '0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
            r_col      <= '0;
            r_row      <= '0;
            r_hold     <= '0;
        end else begin
            valid      <= 1'b0;
            frame_done <= 1'b0;
            if (en) begin
                if (!r_col[0]) begin
                    r_hold <= A;
                end else if (r_row[0]) begin
                    Y          <= w_win;
                    valid      <= 1'b1;
                    frame_done <= w_row_last && w_col_last;
                end
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    // No reset: every entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (!rst && en && r_col[0] && !r_row[0]) begin
            r_lb[w_idx] <= w_pm;
        end
    end

endmodule

// File: tb/tb_max_pool_2x2_stream.sv
// Bench for max_pool_2x2_stream: vector tables, directed sequences and a
// random stream checked cycle-by-cycle against a frame-array reference model.
module tb_max_pool_2x2_stream;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic              clk;
    logic              rst;
    logic              en;
    logic signed [7:0] A;
    logic signed [7:0] Y;
    logic              valid;
    logic              frame_done;

    int checks;
    int errors;

    max_pool_2x2_stream #(
        .In_d_W(8),
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .A         (A),
        .Y         (Y),
        .valid     (valid),
        .frame_done(frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model: whole frame kept in an array, indexed by pixel number
    logic signed [7:0] pix [N];
    int                k;
    logic              m_v;
    logic              m_fd;
    logic signed [7:0] m_y;
    logic signed [7:0] got[$];
    int                fd_cnt;

    typedef struct {
        logic              en;
        logic signed [7:0] a;
        logic              ev;
        logic signed [7:0] ey;
        logic              efd;
    } vec_t;

    vec_t tv2 [N];
    vec_t tv3 [N];

    function automatic logic signed [7:0] mx(input logic signed [7:0] a,
                                             input logic signed [7:0] b);
        return (a > b) ? a : b;
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic signed [7:0] a);
        int row;
        int col;
        rst = r;
        en  = e;
        A   = a;
        @(posedge clk);
        m_v  = 1'b0;
        m_fd = 1'b0;
        if (r) begin
            m_y = 0;
            k   = 0;
        end else if (e) begin
            pix[k] = a;
            row = k / W;
            col = k % W;
            if ((row % 2 == 1) && (col % 2 == 1)) begin
                m_v  = 1'b1;
                m_y  = mx(mx(pix[k-W-1], pix[k-W]), mx(pix[k-1], pix[k]));
                m_fd = (k == N - 1);
            end
            k = (k + 1) % N;
        end
        @(negedge clk);
        chk("valid", valid, m_v);
        chk("frame_done", frame_done, m_fd);
        chk("Y", Y, m_y);
        if (valid === 1'b1) got.push_back(Y);
        if (frame_done === 1'b1) fd_cnt++;
    endtask

    task automatic check_list(input string name, input int n,
                              input logic signed [7:0] exp [8]);
        chk({name, "_count"}, got.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < got.size()) chk({name, "_val"}, got[i], exp[i]);
        end
    endtask

    initial begin
        logic signed [7:0] e4 [8];
        logic signed [7:0] e6 [8];
        checks = 0;
        errors = 0;
        fd_cnt = 0;
        k      = 0;
        m_y    = 0;
        rst    = 1'b1;
        en     = 1'b0;
        A      = '0;

        for (int i = 0; i < N; i++) begin
            tv2[i] = '{1'b1, 8'(i + 1), 1'b0, 8'sd0, 1'b0};
            tv3[i] = '{1'b1, -8'sd100, 1'b0, 8'sd0, 1'b0};
        end
        tv2[5].ev  = 1'b1; tv2[5].ey  = 8'sd6;
        tv2[7].ev  = 1'b1; tv2[7].ey  = 8'sd8;
        tv2[13].ev = 1'b1; tv2[13].ey = 8'sd14;
        tv2[15].ev = 1'b1; tv2[15].ey = 8'sd16; tv2[15].efd = 1'b1;
        tv3[0].a  = -8'sd128;
        tv3[1].a  = -8'sd1;
        tv3[4].a  = -8'sd5;
        tv3[5].a  = -8'sd3;
        tv3[5].ev  = 1'b1; tv3[5].ey  = -8'sd1;
        tv3[7].ev  = 1'b1; tv3[7].ey  = -8'sd100;
        tv3[13].ev = 1'b1; tv3[13].ey = -8'sd100;
        tv3[15].ev = 1'b1; tv3[15].ey = -8'sd100; tv3[15].efd = 1'b1;

        // reset: outputs must read zero
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'sd0);
        chk("reset_Y", Y, 0);
        chk("reset_valid", valid, 0);
        chk("reset_fd", frame_done, 0);

        // contiguous ramp
        for (int i = 0; i < N; i++) begin
            cycle(1'b0, tv2[i].en, tv2[i].a);
            chk("t2_valid", valid, tv2[i].ev);
            chk("t2_fd", frame_done, tv2[i].efd);
            if (tv2[i].ev) chk("t2_Y", Y, tv2[i].ey);
        end

        // signed compare
        for (int i = 0; i < N; i++) begin
            cycle(1'b0, tv3[i].en, tv3[i].a);
            chk("t3_valid", valid, tv3[i].ev);
            chk("t3_fd", frame_done, tv3[i].efd);
            if (tv3[i].ev) chk("t3_Y", Y, tv3[i].ey);
        end

        // bubbles between every pixel
        e4 = '{8'sd6, 8'sd8, 8'sd14, 8'sd16, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
        got.delete();
        for (int i = 0; i < N; i++) begin
            cycle(1'b0, 1'b1, 8'(i + 1));
            cycle(1'b0, 1'b0, 8'sd99);
        end
        check_list("t4", 4, e4);

        // reset mid-frame, with en also high during one reset cycle
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'sd120);
        got.delete();
        cycle(1'b1, 1'b1, 8'sd127);
        cycle(1'b1, 1'b0, 8'sd0);
        chk("t5_rst_valid", got.size(), 0);
        for (int i = 0; i < N; i++) cycle(1'b0, 1'b1, 8'(i + 1));
        check_list("t5", 4, e4);

        // two frames back to back
        e6 = '{8'sd6, 8'sd8, 8'sd14, 8'sd16, 8'sd15, 8'sd13, 8'sd7, 8'sd5};
        got.delete();
        fd_cnt = 0;
        for (int i = 0; i < N; i++) cycle(1'b0, 1'b1, 8'(i + 1));
        for (int i = 1; i <= N; i++) cycle(1'b0, 1'b1, 8'(16 - i));
        check_list("t6", 8, e6);
        chk("t6_frame_done", fd_cnt, 2);

        // random stream with random bubbles and rare resets
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 9) < 7),
                  8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
